// File: rtl/sync_down_counter_tff_pkg.sv
// Shared definitions for the toggle-flip-flop counter library.
package sync_down_counter_tff_pkg;

  localparam int unsigned CNT_WIDTH = 4;

  // Down counters come out of reset at the top of their range.
  function automatic int unsigned down_reset_value(input int unsigned modulus);
    return modulus - 1;
  endfunction

  // Parallel-load values beyond the top of the range saturate to it.
  function automatic int unsigned clamp_load(input int unsigned value,
                                             input int unsigned max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/tff_load_cell.sv
// One-bit T flip-flop with synchronous reset and a parallel-load path.
module tff_load_cell (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic t,
  input  logic ld,
  input  logic ld_d,
  output logic q
);

  // Priority: reset, then load, then toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= rst_val;
    end else if (ld) begin
      q <= ld_d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/sync_down_counter_tff.sv
// Modulo-MODULUS down counter built from T flip-flop cells, with borrow
// output y for cascading, a registered zero flag and a clamped parallel load.
module sync_down_counter_tff
  import sync_down_counter_tff_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_WIDTH,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             y,
  output logic             zero
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(down_reset_value(MODULUS));
  // A full-range modulus wraps for free through binary underflow.
  localparam bit NATURAL_WRAP = (64'(MODULUS) == (64'd1 << WIDTH));

  logic [WIDTH:0]   lower_zero;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] load_val;
  logic             ld;
  logic [WIDTH-1:0] ld_d;
  logic [WIDTH-1:0] q_nxt;

  // Bit i toggles once every lower bit is zero; lower_zero[WIDTH] is q == 0.
  always_comb begin
    lower_zero    = '0;
    t             = '0;
    lower_zero[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]            = en & lower_zero[i];
      lower_zero[i+1] = lower_zero[i] & ~q[i];
    end
  end

  assign y = en & lower_zero[WIDTH];

  // Load path carries either the clamped preset or the forced wrap value.
  always_comb begin
    load_val = WIDTH'(clamp_load(32'(d), MODULUS - 1));
    ld       = load;
    ld_d     = RST_VAL;
    if (load) begin
      ld_d = load_val;
    end else if (!NATURAL_WRAP && y) begin
      ld = 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_load_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RST_VAL[g]),
      .t       (t[g]),
      .ld      (ld),
      .ld_d    (ld_d[g]),
      .q       (q[g])
    );
  end

  // Mirror of the cells' next value so zero tracks q on the same edge.
  assign q_nxt = ld ? ld_d : (q ^ t);

  always_ff @(posedge clk) begin
    if (reset) begin
      zero <= (RST_VAL == '0);
    end else begin
      zero <= (q_nxt == '0);
    end
  end

endmodule
